ram_block_writer: RTL and testbench
===================================

Name: ram_block_writer

Overview:
- Write-side counterpart of the ROM read path.
- Accepts 128-bit AES result blocks from the SIMD pipeline over a valid/ready handshake.
- Serialises each block into eight 16-bit words and writes them to the 8K x 16 data RAM at auto-incrementing 13-bit addresses.
- Uses the same address/data widths as the ROM interface, so it pairs with the same memory map.

Parameters:
- ADDR_W, 13, memory word-address width
- DATA_W, 16, memory word width
- BLOCK_W, 128, input block width; must be a multiple of DATA_W
- WORDS, BLOCK_W/DATA_W (8), words per block; derived, not overridable

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: load base_addr into write pointer, clear counters
- base_addr  in  ADDR_W  start address sampled on start
- in_valid  in  1  input block valid
- in_data  in  BLOCK_W  input block; word 0 = bits [127:112]
- in_ready  out  1  block accepted on clock edge where in_valid && in_ready
- mem_address  out  ADDR_W  RAM write address (registered)
- mem_data  out  DATA_W  RAM write data (registered)
- mem_wren  out  1  RAM write enable (registered)
- busy  out  1  high while a block is being written
- block_done  out  1  one-cycle pulse, coincident with the last word's write
- blocks_written  out  ADDR_W  blocks completed since start/reset; saturates at all-ones
- wrapped  out  1  sticky; set when the pointer wraps from 8191 to 0

Behaviour:
- Reset (async, immediate): state IDLE; ptr=0; word_cnt=0. Outputs: mem_wren=0, mem_address=0, mem_data=0, busy=0, block_done=0, blocks_written=0, wrapped=0. in_ready=1 once reset is released.
- FSM states: IDLE, WRITE.
- IDLE:
  - in_ready = !start.
  - start=1: ptr<=base_addr, blocks_written<=0, wrapped<=0. No accept that cycle (start has priority).
  - Accept (in_valid && in_ready): capture in_data into shift register, word_cnt<=0, go to WRITE.
- WRITE:
  - Each cycle registers mem_wren=1, mem_address=ptr, mem_data=current top word, then ptr<=ptr+1 (mod 2^13) and shifts the register by DATA_W.
  - First write is visible in the cycle after the accept edge. Eight consecutive write cycles; no gaps.
  - busy=1 throughout WRITE.
- Last word (word_cnt==7):
  - block_done=1 in the same cycle as the word-7 write.
  - blocks_written increments, holding at 8191.
  - in_ready=1 in this cycle, so back-to-back blocks are accepted. If accepted, WRITE continues with no idle cycle (sustained rate: 1 word/cycle). Otherwise return to IDLE with mem_wren=0 next cycle.
  - in_ready=0 during word_cnt 0..6.
- start while in WRITE: ignored entirely; ptr and counters unchanged.
- Wrap-around: ptr 8191 -> 0 mid-block is legal; write continues at 0 and wrapped is set.
- Latency: accept edge to first write = 1 cycle; accept edge to block_done = 8 cycles.
- in_data is only sampled on the accept edge; later changes have no effect.
- Reset mid-block: remaining words are discarded, mem_wren drops to 0 asynchronously, and no partial-block count is recorded.

Decomposition:
- Shared package (aes_mem_pkg): ADDR_W, DATA_W, BLOCK_W, WORDS constants; state_t enum {IDLE, WRITE}. The same ADDR_W/DATA_W constants are used by read_ROM.
- One natural sub-module: block_serializer. It is the 128->16 shift register with load/shift and a word counter, exposing last_word. The FSM, pointer and counters stay in the top level.

Test Plan:
1. Single block, aligned: start base_addr=0x0010, then block 0x0011_2233_4455_6677_8899_AABB_CCDD_EEFF -> writes 0x0011@0x0010 .. 0xEEFF@0x0017 on 8 consecutive cycles; block_done with the last write; blocks_written=1; in_ready=0 during words 0..6.
2. Back-to-back: in_valid held high with 3 blocks from base 0x0100 -> 24 consecutive writes at 0x0100..0x0117 with no idle cycle; block_done pulses at write cycles 8, 16 and 24; blocks_written=3.
3. Wrap: base_addr=0x1FFC, one block -> writes at 0x1FFC..0x1FFF then 0x0000..0x0003; wrapped=1 from the first write to 0x0000.
4. Start priority and start-while-busy: start and in_valid together in IDLE -> no accept that cycle, accept next cycle. Start pulsed with base 0x0500 during WRITE -> ignored; the current block completes at its original addresses.
5. Reset mid-block: assert reset after the 3rd write -> mem_wren=0 immediately; all outputs at reset values; after release, a new block from base 0 writes at 0x0000..0x0007 and blocks_written=1.
6. Backpressure/hold: in_valid=0 after one block -> mem_wren=0 one cycle after block_done, state IDLE, in_ready=1. Changing in_data while WRITE is in progress has no effect on the written words.

Source files
------------

// File: rtl/aes_mem_pkg.sv
// Shared constants and FSM encoding for the AES data-RAM write path.
// The ROM read path uses the same ADDR_W/DATA_W, so both share one memory map.
package aes_mem_pkg;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 16;
  localparam int BLOCK_W = 128;
  localparam int WORDS   = BLOCK_W / DATA_W;
  localparam int CNT_W   = $clog2(WORDS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Saturating increment: sticks at all-ones instead of rolling over.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/block_serializer.sv
// Loads one BLOCK_W block and presents it DATA_W bits at a time, MSB word first.
// The word counter tells the controller when the final word is being handed out.
module block_serializer
  import aes_mem_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic               shift_i,
  output logic [DATA_W-1:0]  word_o,
  output logic               last_word_o
);

  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // A load wins over a shift so a back-to-back block replaces the spent register.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = block_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[BLOCK_W-DATA_W-1:0], {DATA_W{1'b0}}};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o      = shreg_q[BLOCK_W-1 -: DATA_W];
  assign last_word_o = (cnt_q == CNT_W'(WORDS - 1));

endmodule

// File: rtl/ram_block_writer.sv
// Takes 128-bit AES result blocks and writes them as eight 16-bit words to the
// data RAM at auto-incrementing addresses, one word per cycle with no gaps.
module ram_block_writer
  import aes_mem_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_data,
  output logic               mem_wren,
  output logic               busy,
  output logic               block_done,
  output logic [ADDR_W-1:0]  blocks_written,
  output logic               wrapped
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_wren_q, mem_wren_d;
  logic                block_done_q, block_done_d;
  logic [ADDR_W-1:0]   blocks_written_q, blocks_written_d;
  logic                wrapped_q, wrapped_d;
  logic                wrap_pend_q, wrap_pend_d;

  logic                accept;
  logic                write_en;
  logic                restart;
  logic [DATA_W-1:0]   cur_word;
  logic                last_word;

  block_serializer u_ser (
    .clock       (clock),
    .reset       (reset),
    .load_i      (accept),
    .block_i     (in_data),
    .shift_i     (write_en),
    .word_o      (cur_word),
    .last_word_o (last_word)
  );

  // In WRITE the next block is taken while the last word is being registered.
  assign in_ready = (state_q == IDLE) ? !start : last_word;
  assign accept   = in_valid && in_ready;
  assign write_en = (state_q == WRITE);
  assign restart  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WRITE;
      WRITE:   if (last_word && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d            = ptr_q;
    mem_address_d    = mem_address_q;
    mem_data_d       = mem_data_q;
    mem_wren_d       = write_en;
    block_done_d     = write_en && last_word;
    blocks_written_d = blocks_written_q;
    wrapped_d        = wrapped_q;
    wrap_pend_d      = wrap_pend_q;

    if (restart) begin
      ptr_d            = base_addr;
      blocks_written_d = '0;
      wrapped_d        = 1'b0;
      wrap_pend_d      = 1'b0;
    end

    if (write_en) begin
      mem_address_d = ptr_q;
      mem_data_d    = cur_word;
      ptr_d         = ptr_q + 1'b1;
      // wrapped is raised on the write that lands on address 0 after rolling over.
      if (wrap_pend_q) wrapped_d = 1'b1;
      wrap_pend_d   = &ptr_q;
    end

    if (block_done_d) blocks_written_d = sat_inc(blocks_written_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      mem_address_q    <= '0;
      mem_data_q       <= '0;
      mem_wren_q       <= 1'b0;
      block_done_q     <= 1'b0;
      blocks_written_q <= '0;
      wrapped_q        <= 1'b0;
      wrap_pend_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      mem_address_q    <= mem_address_d;
      mem_data_q       <= mem_data_d;
      mem_wren_q       <= mem_wren_d;
      block_done_q     <= block_done_d;
      blocks_written_q <= blocks_written_d;
      wrapped_q        <= wrapped_d;
      wrap_pend_q      <= wrap_pend_d;
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_data       = mem_data_q;
  assign mem_wren       = mem_wren_q;
  assign block_done     = block_done_q;
  assign blocks_written = blocks_written_q;
  assign wrapped        = wrapped_q;
  assign busy           = write_en || mem_wren_q;

endmodule

// File: tb/tb_ram_block_writer.sv
// Bench for ram_block_writer: a queue-based word model checked every cycle,
// plus literal checks of addresses, data and timing for each scenario.
module tb_ram_block_writer;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [12:0]  base_addr;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic [12:0]  mem_address;
  logic [15:0]  mem_data;
  logic         mem_wren;
  logic         busy;
  logic         block_done;
  logic [12:0]  blocks_written;
  logic         wrapped;

  ram_block_writer dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_wren       (mem_wren),
    .busy           (busy),
    .block_done     (block_done),
    .blocks_written (blocks_written),
    .wrapped        (wrapped)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Model: a block in flight is simply a queue of words still to be written.
  typedef struct packed { logic [15:0] d; logic last; } wq_t;
  wq_t         mq[$];
  wq_t         w;
  logic [12:0] m_ptr;
  int          m_bw;
  bit          m_wrapped, m_wrap_arm;
  bit          e_wren, e_done;
  logic [12:0] e_addr;
  logic [15:0] e_data;
  bit          m_idle, m_rdy, m_acc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ptr = 0; m_bw = 0; m_wrapped = 0; m_wrap_arm = 0;
      e_wren = 0; e_done = 0; e_addr = 0; e_data = 0;
    end else begin
      m_idle = (mq.size() == 0);
      m_rdy  = m_idle ? !start : (mq.size() == 1);
      m_acc  = in_valid && m_rdy;
      if (m_idle && start) begin
        m_ptr = base_addr; m_bw = 0; m_wrapped = 0; m_wrap_arm = 0;
      end
      e_wren = 0;
      e_done = 0;
      if (!m_idle) begin
        w = mq.pop_front();
        e_wren = 1; e_addr = m_ptr; e_data = w.d; e_done = w.last;
        if (m_wrap_arm) m_wrapped = 1;
        m_wrap_arm = (m_ptr == 13'h1FFF);
        m_ptr = m_ptr + 13'd1;
        if (w.last && m_bw < 8191) m_bw++;
      end
      if (m_acc)
        for (int i = 0; i < 8; i++) mq.push_back('{d: in_data[127-16*i -: 16], last: (i == 7)});
    end
  end

  typedef struct { int c; logic [12:0] a; logic [15:0] d; logic dn; logic wr; } log_t;
  log_t wlog[$];

  always @(negedge clock) begin
    cyc++;
    chk("mem_wren", mem_wren, e_wren);
    chk("block_done", block_done, e_done);
    chk("blocks_written", blocks_written, m_bw);
    chk("wrapped", wrapped, m_wrapped);
    chk("busy", busy, (mq.size() != 0) || e_wren);
    chk("in_ready", in_ready, (mq.size() == 0) ? !start : (mq.size() == 1));
    if (e_wren) begin
      chk("mem_address", mem_address, e_addr);
      chk("mem_data", mem_data, e_data);
    end
    if (mem_wren) wlog.push_back('{c: cyc, a: mem_address, d: mem_data, dn: block_done, wr: wrapped});
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [12:0] b);
    start = 1; base_addr = b;
    tick();
    start = 0;
  endtask

  task automatic send_block(input logic [127:0] d, output int acc_cyc);
    int n = 0;
    in_valid = 1; in_data = d;
    #1;
    while (!in_ready && n < 40) begin tick(); n++; end
    if (n >= 40) timeout("accept_wait");
    tick();
    acc_cyc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    if (n >= 40) timeout("idle_wait");
  endtask

  localparam logic [127:0] B1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] B2 = 128'h1001_1002_1003_1004_1005_1006_1007_1008;
  localparam logic [127:0] B3 = 128'h2001_2002_2003_2004_2005_2006_2007_2008;
  localparam logic [127:0] B4 = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
  localparam logic [127:0] B5 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    logic [127:0] blk [3];
    reset = 1; start = 0; base_addr = 0; in_valid = 0; in_data = '0;
    #2;
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_bw", blocks_written, 0);
    tick(2);
    reset = 0;
    tick();
    chk("rst_ready", in_ready, 1);

    // 1: single aligned block
    do_start(13'h0010);
    wlog.delete();
    send_block(B1, acc);
    wait_idle();
    chk("t1_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t1_a0", wlog[0].a, 13'h0010);
      chk("t1_d0", wlog[0].d, 16'h0011);
      chk("t1_a7", wlog[7].a, 13'h0017);
      chk("t1_d7", wlog[7].d, 16'hEEFF);
      chk("t1_d3", wlog[3].d, 16'h6677);
      chk("t1_done7", wlog[7].dn, 1);
      chk("t1_done6", wlog[6].dn, 0);
      chk("t1_lat_first", wlog[0].c - acc, 2);
      chk("t1_lat_done", wlog[7].c - acc, 9);
    end
    chk("t1_bw", blocks_written, 1);

    // 2: three back-to-back blocks
    blk[0] = B2; blk[1] = B3; blk[2] = B1;
    do_start(13'h0100);
    wlog.delete();
    in_valid = 1;
    for (int b = 0; b < 3; b++) begin
      in_data = blk[b];
      #1;
      n = 0;
      while (!in_ready && n < 40) begin tick(); n++; end
      if (n >= 40) timeout("t2_accept");
      tick();
    end
    in_valid = 0;
    wait_idle();
    chk("t2_count", wlog.size(), 24);
    if (wlog.size() == 24) begin
      chk("t2_span", wlog[23].c - wlog[0].c, 23);
      chk("t2_a0", wlog[0].a, 13'h0100);
      chk("t2_a23", wlog[23].a, 13'h0117);
      chk("t2_d8", wlog[8].d, 16'h2001);
      chk("t2_d23", wlog[23].d, 16'hEEFF);
      chk("t2_done7", wlog[7].dn, 1);
      chk("t2_done15", wlog[15].dn, 1);
      chk("t2_done23", wlog[23].dn, 1);
      chk("t2_done8", wlog[8].dn, 0);
    end
    chk("t2_bw", blocks_written, 3);

    // 3: wrap-around
    do_start(13'h1FFC);
    wlog.delete();
    send_block(B4, acc);
    wait_idle();
    chk("t3_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t3_a3", wlog[3].a, 13'h1FFF);
      chk("t3_a4", wlog[4].a, 13'h0000);
      chk("t3_a7", wlog[7].a, 13'h0003);
      chk("t3_wr3", wlog[3].wr, 0);
      chk("t3_wr4", wlog[4].wr, 1);
    end
    chk("t3_wrapped", wrapped, 1);

    // 4: start priority and start while busy
    start = 1; base_addr = 13'h0200; in_valid = 1; in_data = B5;
    #1;
    chk("t4_ready_start", in_ready, 0);
    tick();
    start = 0;
    #1;
    chk("t4_ready_after", in_ready, 1);
    wlog.delete();
    tick();
    in_valid = 0;
    chk("t4_wrapped_clr", wrapped, 0);
    tick(2);
    start = 1; base_addr = 13'h0500;
    tick();
    start = 0;
    wait_idle();
    chk("t4_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t4_a0", wlog[0].a, 13'h0200);
      chk("t4_a7", wlog[7].a, 13'h0207);
      chk("t4_d0", wlog[0].d, 16'hDEAD);
    end
    chk("t4_bw", blocks_written, 1);

    // 5: reset in the middle of a block
    do_start(13'h0040);
    wlog.delete();
    send_block(B2, acc);
    n = 0;
    while (wlog.size() < 3 && n < 40) begin @(negedge clock); #1; n++; end
    if (n >= 40) timeout("t5_third_write");
    reset = 1;
    #1;
    chk("t5_wren", mem_wren, 0);
    chk("t5_busy", busy, 0);
    chk("t5_bw", blocks_written, 0);
    chk("t5_addr", mem_address, 0);
    chk("t5_done", block_done, 0);
    @(posedge clock); #1;
    reset = 0;
    wlog.delete();
    send_block(B3, acc);
    wait_idle();
    chk("t5_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t5_a0", wlog[0].a, 13'h0000);
      chk("t5_a7", wlog[7].a, 13'h0007);
      chk("t5_d7", wlog[7].d, 16'h2008);
    end
    chk("t5_bw1", blocks_written, 1);

    // 6: input changes mid-write, then drain to idle
    wlog.delete();
    send_block(B1, acc);
    in_data = ~B1;
    tick(3);
    in_data = '0;
    n = 0;
    while (!block_done && n < 40) begin @(negedge clock); #1; n++; end
    if (n >= 40) timeout("t6_done_wait");
    chk("t6_ready_at_done", in_ready, 1);
    @(negedge clock); #1;
    chk("t6_wren_after", mem_wren, 0);
    chk("t6_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t6_d4", wlog[4].d, 16'h8899);
      chk("t6_d7", wlog[7].d, 16'hEEFF);
      chk("t6_a0", wlog[0].a, 13'h0008);
    end
    chk("t6_bw", blocks_written, 2);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
